pixel_serializer: RTL and testbench
===================================

Name: pixel_serializer

Overview:
- Transmit-side counterpart of pixel_collector: accepts whole pixels on a valid/ready interface and emits them as a byte stream, most-significant byte first.
- Sits between the frame/pixel source and the byte link that feeds pixel_collector on the far end.
- Tracks pixel position within a frame and flags the final byte of each frame.
- Sustains one byte per clock under continuous input and no backpressure.

Parameters:
- pixel_bytes_p, 2, bytes per pixel (>=1); pixel width = pixel_bytes_p*8.
- frame_width_p, 80, pixels per line.
- frame_height_p, 60, lines per frame.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- pixel_i  input  pixel_bytes_p*8  pixel to serialize.
- valid_i  input  1  pixel_i valid.
- ready_o  output  1  serializer can accept pixel_i this cycle.
- data_o  output  8  current output byte.
- valid_o  output  1  data_o valid.
- ready_i  input  1  downstream accepts data_o this cycle.
- last_o  output  1  data_o is the final byte of the final pixel of a frame; qualified by valid_o.

Behaviour:
- Reset: while reset_ni=0, all state clears immediately (asynchronous).
  - Outputs during reset: valid_o=0, data_o=0, last_o=0, ready_o=0.
  - Counters cleared: byte index = pixel_bytes_p-1, x=0, y=0, holding register empty.
- After reset release: ready_o=1 in the first cycle.
- Input transfer: occurs on a rising edge with valid_i & ready_o; the pixel is captured into the holding register.
- Output transfer: occurs on a rising edge with valid_o & ready_i.
- State:
  - loaded flag: holding register occupied.
  - byte_idx: counts down from pixel_bytes_p-1 to 0.
  - x counter: 0..frame_width_p-1.
  - y counter: 0..frame_height_p-1.
- Output fields:
  - valid_o = loaded.
  - data_o = hold[byte_idx*8 +: 8] when loaded, else 8'h00.
- ready_o = reset_ni & (!loaded | (byte_idx==0 & ready_i)).
  - Combinational from ready_i only; there is no path from valid_i to ready_o.
- Latency: a pixel accepted at edge N has its MSB byte on data_o (valid_o=1) in the cycle after edge N.
- Backpressure: while valid_o=1 & ready_i=0, data_o, last_o, byte_idx and hold are stable.
- On output transfer with byte_idx>0: byte_idx decrements.
- On output transfer with byte_idx==0 (end of pixel):
  - byte_idx reloads to pixel_bytes_p-1.
  - x/y advance: x wraps at frame_width_p-1 and increments y; y wraps at frame_height_p-1 to 0.
  - If valid_i is also high in the same cycle (ready_o=1), the new pixel loads and loaded stays 1, giving gapless output.
  - Otherwise loaded clears.
- last_o = loaded & byte_idx==0 & x==frame_width_p-1 & y==frame_height_p-1.
- pixel_bytes_p=1: every byte is a pixel end; ready_o = !loaded | ready_i.
- Input while loaded and not at the final byte: ready_o=0, pixel_i ignored, and the source must hold it.
- Reset mid-pixel: remaining bytes are discarded, the frame position returns to (0,0), and no partial byte is emitted after release.
- No error flagging; frame counters wrap silently.

Test Plan:
- Single pixel:
  - Stimulus: after reset, ready_i=1, one pixel 16'hABCD.
  - Response: data_o=8'hAB then 8'hCD on consecutive cycles, valid_o high exactly 2 cycles; ready_o low during the AB cycle.
- Back-to-back:
  - Stimulus: 80 pixels, valid_i held high, ready_i=1.
  - Response: 160 bytes with valid_o continuously high; ready_o pulses high on every second cycle; byte order MSB, LSB per pixel.
- Backpressure:
  - Stimulus: pixel 16'h1234, ready_i low for 3 cycles while data_o=8'h12.
  - Response: data_o stays 8'h12 with valid_o=1, then 8'h34 emitted; no byte lost or duplicated.
- Frame end:
  - Stimulus: stream 4800 pixels (80x60) with pixel value = index.
  - Response: last_o=1 only on the LSB byte of pixel 4799 (16'h12BF); next frame's first pixel has last_o=0 and the counters restart.
- Reset mid-pixel:
  - Stimulus: assert reset_ni=0 asynchronously while data_o=8'hAB (the MSB of 16'hABCD) is pending.
  - Response: valid_o, data_o and ready_o drop to 0 without waiting for a clock edge. After release, 16'h5566 yields 55, 66 and the position restarts at (0,0).
- Loopback with pixel_bytes_p=3:
  - Stimulus: connect to pixel_collector (pixel_bytes_p=3); send 24'hA1B2C3 and 24'h0000FF.
  - Response: byte stream A1, B2, C3, 00, 00, FF; the collector outputs both pixels unchanged, in order.

Source files
------------

// File: rtl/pixel_serializer.sv
`timescale 1ns/1ps
// Pixel-to-byte serializer: MSB first, one byte per clock, last_o on the final byte of each frame.
// A new pixel can load on the same edge as the previous pixel's last byte, so the output stays gapless.
module pixel_serializer #(
  parameter int pixel_bytes_p  = 2,
  parameter int frame_width_p  = 80,
  parameter int frame_height_p = 60
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [pixel_bytes_p*8-1:0] pixel_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [7:0]                 data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o
);

  localparam int PW = pixel_bytes_p * 8;
  localparam int BW = (pixel_bytes_p > 1) ? $clog2(pixel_bytes_p) : 1;
  localparam int XW = (frame_width_p > 1) ? $clog2(frame_width_p) : 1;
  localparam int YW = (frame_height_p > 1) ? $clog2(frame_height_p) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(pixel_bytes_p - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(frame_width_p - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(frame_height_p - 1);

  logic          loaded_q, loaded_d;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [PW-1:0] hold_q, hold_d;

  logic       pix_end;
  logic       in_xfer;
  logic       out_xfer;
  logic [7:0] byte_sel;

  assign pix_end  = (byte_idx_q == '0);
  assign out_xfer = loaded_q & ready_i;
  // ready_o depends on ready_i only, never on valid_i
  assign ready_o  = reset_ni & (!loaded_q | (pix_end & ready_i));
  assign in_xfer  = valid_i & ready_o;

  always_comb begin
    byte_sel = 8'h00;
    for (int i = 0; i < pixel_bytes_p; i++) begin
      if (byte_idx_q == BW'(i)) byte_sel = hold_q[i*8 +: 8];
    end
  end

  assign valid_o = loaded_q;
  assign data_o  = loaded_q ? byte_sel : 8'h00;
  assign last_o  = loaded_q & pix_end & (x_q == X_LAST) & (y_q == Y_LAST);

  always_comb begin
    loaded_d   = loaded_q;
    byte_idx_d = byte_idx_q;
    x_d        = x_q;
    y_d        = y_q;
    hold_d     = hold_q;
    if (out_xfer) begin
      if (!pix_end) begin
        byte_idx_d = byte_idx_q - 1'b1;
      end else begin
        byte_idx_d = BYTE_LAST;
        loaded_d   = 1'b0;
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
    end
    // a load on the final-byte edge overrides the clear above
    if (in_xfer) begin
      hold_d     = pixel_i;
      loaded_d   = 1'b1;
      byte_idx_d = BYTE_LAST;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      loaded_q   <= 1'b0;
      byte_idx_q <= BYTE_LAST;
      x_q        <= '0;
      y_q        <= '0;
      hold_q     <= '0;
    end else begin
      loaded_q   <= loaded_d;
      byte_idx_q <= byte_idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
`timescale 1ns/1ps
// Scoreboarded bench for pixel_serializer: a pixel-count model predicts bytes and frame-end flags.
module tb_pixel_serializer;
  localparam int PB = 2;
  localparam int FW = 80;
  localparam int FH = 60;
  localparam int FRAME = FW * FH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pixel_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic        ready_o, valid_o, last_o;
  logic [7:0]  data_o;

  logic [23:0] p3_pix = '0;
  logic        p3_vld = 1'b0;
  logic        p3_rdy_o, p3_vo, p3_lo;
  logic [7:0]  p3_do;

  pixel_serializer #(.pixel_bytes_p(PB), .frame_width_p(FW), .frame_height_p(FH)) dut (
    .clk_i(clk), .reset_ni(rst_n), .pixel_i(pixel_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o)
  );

  pixel_serializer #(.pixel_bytes_p(3), .frame_width_p(2), .frame_height_p(2)) dut3 (
    .clk_i(clk), .reset_ni(rst_n), .pixel_i(p3_pix), .valid_i(p3_vld), .ready_o(p3_rdy_o),
    .data_o(p3_do), .valid_o(p3_vo), .ready_i(1'b1), .last_o(p3_lo)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;
  int pix_count = 0;
  int last_cnt = 0;
  int cyc = 0;
  int first_acc = -1;
  int last_acc = -1;
  bit track = 1'b0;
  bit rand_rdy = 1'b0;
  logic [7:0] p3_bytes[$];
  int p3_last_idx = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Reference model: each accepted pixel yields its bytes MSB first; the last byte of
  // every FRAME-th pixel carries the frame-end flag.
  always @(negedge clk) begin
    if (valid_i && ready_o) begin
      for (int b = PB - 1; b >= 0; b--)
        exp_q.push_back({(b == 0) && (pix_count % FRAME == FRAME - 1), pixel_i[b*8 +: 8]});
      pix_count++;
      if (track) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("spurious_byte", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("byte", {23'b0, last_o, data_o}, {23'b0, e});
        if (last_o) last_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (p3_vo) begin
      if (p3_lo) p3_last_idx = p3_bytes.size();
      p3_bytes.push_back(p3_do);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [15:0] p);
    int n = 0;
    pixel_i = p;
    valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 1000) begin @(negedge clk); n++; end
    if (!ready_o) check("accept_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  logic [23:0] p3_src[4];
  logic [23:0] asm_pix;
  int n;

  initial begin
    #3;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_last", last_o, 0);
    check("rst_ready", ready_o, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("ready_after_reset", ready_o, 1);
    @(posedge clk); #1;

    // single pixel
    send(16'hABCD); valid_i = 1'b0;
    check("single_msb", data_o, 8'hAB);
    check("single_msb_vld", valid_o, 1);
    check("single_ready_low", ready_o, 0);
    @(posedge clk); #1;
    check("single_lsb", data_o, 8'hCD);
    check("single_lsb_vld", valid_o, 1);
    @(posedge clk); #1;
    check("single_done", valid_o, 0);

    // backpressure on the MSB byte
    ready_i = 1'b0;
    send(16'h1234); valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", data_o, 8'h12);
      check("bp_hold_vld", valid_o, 1);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_lsb", data_o, 8'h34);
    @(posedge clk); #1;

    // asynchronous reset with a byte pending
    ready_i = 1'b0;
    send(16'hABCD); valid_i = 1'b0;
    check("pre_reset_msb", data_o, 8'hAB);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", valid_o, 0);
    check("async_rst_data", data_o, 0);
    check("async_rst_ready", ready_o, 0);
    exp_q.delete();
    pix_count = 0;
    @(negedge clk); rst_n = 1'b1; ready_i = 1'b1;
    @(posedge clk); #1;

    // 5566 then a full frame's worth of indexed pixels, plus a few of the next frame
    track = 1'b1;
    send(16'h5566);
    for (int i = 1; i < FRAME + 3; i++) send(16'(i));
    valid_i = 1'b0;
    track = 1'b0;
    check("gapless_span", last_acc - first_acc, 2 * (FRAME + 2));
    repeat (6) @(posedge clk);
    check("frame_last_count", last_cnt, 1);

    // randomized traffic and backpressure
    #1 rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    valid_i = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk); #2 ready_i = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    check("drain_empty", exp_q.size(), 0);
    check("last_count_final", last_cnt, 1);

    // three-byte pixels, one 2x2 frame
    p3_src[0] = 24'hA1B2C3; p3_src[1] = 24'h0000FF; p3_src[2] = 24'h123456; p3_src[3] = 24'h789ABC;
    p3_bytes.delete();
    for (int i = 0; i < 4; i++) begin
      p3_pix = p3_src[i];
      p3_vld = 1'b1;
      n = 0;
      @(negedge clk);
      while (!p3_rdy_o && n < 100) begin @(negedge clk); n++; end
      if (!p3_rdy_o) check("p3_accept_timeout", n, 0);
      @(posedge clk); #1;
    end
    p3_vld = 1'b0;
    repeat (6) @(posedge clk);
    check("p3_byte_count", p3_bytes.size(), 12);
    while (p3_bytes.size() < 12) p3_bytes.push_back(8'hxx);
    for (int j = 0; j < 12; j++)
      check("p3_byte", p3_bytes[j], (p3_src[j / 3] >> (8 * (2 - j % 3))) & 24'hFF);
    for (int i = 0; i < 4; i++) begin
      asm_pix = {p3_bytes[3*i], p3_bytes[3*i+1], p3_bytes[3*i+2]};
      check("p3_pixel", asm_pix, p3_src[i]);
    end
    check("p3_last_idx", p3_last_idx, 11);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
